// File: rtl/keypad_multi_operand_entry_if.sv
// keypad_multi_operand_entry_if: keypad matrix lines plus the operand/key results handed to the datapath.
interface keypad_multi_operand_entry_if #(
    parameter int NUM_OPS    = 2,
    parameter int MAX_DIGITS = 3,
    parameter int OUT_W      = 10
);
    localparam int IW = $clog2(NUM_OPS + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    logic [3:0]               col;
    logic [3:0]               row;
    logic [NUM_OPS*OUT_W-1:0] operands;
    logic [NUM_OPS-1:0]       op_valid;
    logic [3:0]               key_code;
    logic                     key_valid;
    logic [IW-1:0]            op_idx;
    logic [DW-1:0]            digit_cnt;
    logic                     all_done;
    modport master (input col, output row, operands, op_valid, key_code, key_valid, op_idx, digit_cnt, all_done);
    modport slave  (output col, input row, operands, op_valid, key_code, key_valid, op_idx, digit_cnt, all_done);
endinterface

// File: rtl/keypad_multi_operand_entry.sv
// keypad_multi_operand_entry: 4x4 keypad scan, frame debounce and multi-operand decimal entry.
module keypad_multi_operand_entry #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int NUM_OPS         = 2,
    parameter int MAX_DIGITS      = 3,
    parameter int OUT_W           = 10
) (
    input logic clk,
    input logic rst,
    keypad_multi_operand_entry_if.master bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int IW = $clog2(NUM_OPS + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
    localparam logic [BW-1:0] DB = BW'(DEBOUNCE_FRAMES);
    localparam logic [DW-1:0] MAXD = DW'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            div_q, div_d;
    logic [1:0]               row_sel_q, row_sel_d;
    logic [3:0]               sync1_q, sync2_q;
    logic [1:0]               hits_q, hits_d;
    logic [3:0]               fcode_q, fcode_d;
    logic [BW-1:0]            cnt_q, cnt_d;
    logic [3:0]               cand_q, cand_d;
    logic [3:0]               key_code_q, key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic [OUT_W-1:0]         acc_q, acc_d;
    logic [DW-1:0]            dcnt_q, dcnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [NUM_OPS*OUT_W-1:0] operands_q, operands_d;
    logic [NUM_OPS-1:0]       op_valid_q, op_valid_d;
    logic                     done_q, done_d;

    logic       slot_end, frame_done, is_key;
    logic [3:0] low, code_new;
    logic [2:0] nlow, sum;
    logic [1:0] lcol, hits_new;

    // Scan timing and per-frame hit accumulation (counts saturate at 2 = ghost/multi-key)
    always_comb begin
        slot_end   = div_q == CW'(SCAN_DIV - 1);
        div_d      = slot_end ? '0 : div_q + CW'(1);
        row_sel_d  = slot_end ? row_sel_q + 2'd1 : row_sel_q;
        low        = ~sync2_q;
        nlow       = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
        lcol       = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
        sum        = {1'b0, (row_sel_q == 2'd0) ? 2'd0 : hits_q} + nlow;
        hits_new   = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_new   = (nlow == 3'd1) ? KEYMAP[{row_sel_q, lcol, 2'b00} +: 4] : (row_sel_q == 2'd0) ? 4'd0 : fcode_q;
        hits_d     = slot_end ? hits_new : hits_q;
        fcode_d    = slot_end ? code_new : fcode_q;
        frame_done = slot_end && row_sel_q == 2'd3;
        is_key     = hits_new == 2'd1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        if (frame_done) begin
            case (state_q)
                IDLE: if (is_key) begin
                    cand_d = code_new;
                    cnt_d  = BW'(1);
                    if (DEBOUNCE_FRAMES == 1) begin
                        state_d     = HELD;
                        key_valid_d = 1'b1;
                    end else state_d = PRESS_WAIT;
                end
                PRESS_WAIT: if (is_key && code_new == cand_q) begin
                    cnt_d = cnt_q + BW'(1);
                    if (cnt_d == DB) begin
                        state_d     = HELD;
                        key_valid_d = 1'b1;
                    end
                end else state_d = IDLE;
                HELD: if (!is_key) begin
                    cnt_d   = BW'(1);
                    state_d = (DEBOUNCE_FRAMES == 1) ? IDLE : RELEASE_WAIT;
                end
                default: if (is_key) state_d = HELD;
                else begin
                    cnt_d   = cnt_q + BW'(1);
                    state_d = (cnt_d == DB) ? IDLE : RELEASE_WAIT;
                end
            endcase
        end
        key_code_d = key_valid_d ? cand_d : key_code_q;
    end

    // Entry editing acts on the registered key, one cycle after the pulse
    always_comb begin
        acc_d      = acc_q;
        dcnt_d     = dcnt_q;
        idx_d      = idx_q;
        operands_d = operands_q;
        op_valid_d = op_valid_q;
        done_d     = done_q;
        if (key_valid_q) begin
            if (key_code_q == 4'd13) begin
                acc_d      = '0;
                dcnt_d     = '0;
                idx_d      = '0;
                operands_d = '0;
                op_valid_d = '0;
                done_d     = 1'b0;
            end else if (!done_q) begin
                if (key_code_q <= 4'd9 && dcnt_q != MAXD) begin
                    acc_d  = acc_q * OUT_W'(10) + OUT_W'(key_code_q);
                    dcnt_d = dcnt_q + DW'(1);
                end else if (key_code_q == 4'd14 && dcnt_q != '0) begin
                    acc_d  = acc_q / OUT_W'(10);
                    dcnt_d = dcnt_q - DW'(1);
                end else if (key_code_q == 4'd15 && dcnt_q != '0) begin
                    for (int i = 0; i < NUM_OPS; i++) begin
                        if (idx_q == IW'(i)) begin
                            operands_d[i*OUT_W +: OUT_W] = acc_q;
                            op_valid_d[i]                = 1'b1;
                        end
                    end
                    acc_d  = '0;
                    dcnt_d = '0;
                    idx_d  = idx_q + IW'(1);
                    done_d = idx_d == IW'(NUM_OPS);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            row_sel_q   <= '0;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            hits_q      <= '0;
            fcode_q     <= '0;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            acc_q       <= '0;
            dcnt_q      <= '0;
            idx_q       <= '0;
            operands_q  <= '0;
            op_valid_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_sel_q   <= row_sel_d;
            sync1_q     <= bus.col;
            sync2_q     <= sync1_q;
            hits_q      <= hits_d;
            fcode_q     <= fcode_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            idx_q       <= idx_d;
            operands_q  <= operands_d;
            op_valid_q  <= op_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.row       = ~(4'b0001 << row_sel_q);
    assign bus.operands  = operands_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.op_idx    = idx_q;
    assign bus.digit_cnt = dcnt_q;
    assign bus.all_done  = done_q;
endmodule

// File: tb/tb_keypad_multi_operand_entry.sv
// tb_keypad_multi_operand_entry: keypad matrix model, vector table, corner sequences and random keys vs. an entry model.
module tb_keypad_multi_operand_entry;
    localparam int SD = 4, DBF = 2, NO = 2, MD = 3, OW = 10, FR = 4 * SD;

    typedef struct {
        int key; int op0; int op1; int valid; int idx; int dcnt; int done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  colv;
    int checks = 0, errors = 0, kv_cnt = 0, kv_last = 0, b = 0;
    int m_acc, m_dcnt, m_idx, m_done, m_valid;
    int m_ops [NO];
    int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    vec_t tbl [17];

    keypad_multi_operand_entry_if #(.NUM_OPS(NO), .MAX_DIGITS(MD), .OUT_W(OW)) bus ();

    keypad_multi_operand_entry #(
        .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DBF), .NUM_OPS(NO), .MAX_DIGITS(MD), .OUT_W(OW)
    ) dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    // Pressed switches short their column to whichever row is driven low
    always_comb begin
        colv = 4'hF;
        for (int r = 0; r < 4; r++) if (!bus.row[r]) colv = colv & ~pressed[r*4 +: 4];
    end
    assign bus.col = colv;

    always @(negedge clk) if (bus.key_valid === 1'b1) begin
        kv_cnt  = kv_cnt + 1;
        kv_last = int'(bus.key_code);
    end

    function automatic logic [15:0] key_bit(input int k);
        for (int i = 0; i < 16; i++) if (kmap[i] == k) return 16'(1) << i;
        return '0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input int op0, op1, valid, idx, dcnt, done);
        chk("operand0", int'(bus.operands[OW-1:0]), op0);
        chk("operand1", int'(bus.operands[2*OW-1:OW]), op1);
        chk("op_valid", int'(bus.op_valid), valid);
        chk("op_idx", int'(bus.op_idx), idx);
        chk("digit_cnt", int'(bus.digit_cnt), dcnt);
        chk("all_done", int'(bus.all_done), done);
    endtask

    task automatic check_model();
        check_state(m_ops[0], m_ops[1], m_valid, m_idx, m_dcnt, m_done);
    endtask

    task automatic m_clear();
        m_acc = 0; m_dcnt = 0; m_idx = 0; m_done = 0; m_valid = 0;
        foreach (m_ops[i]) m_ops[i] = 0;
    endtask

    task automatic m_apply(input int k);
        if (k == 13) m_clear();
        else if (m_done == 0) begin
            if (k <= 9 && m_dcnt < MD) begin
                m_acc = m_acc * 10 + k; m_dcnt++;
            end else if (k == 14 && m_dcnt > 0) begin
                m_acc = m_acc / 10; m_dcnt--;
            end else if (k == 15 && m_dcnt > 0) begin
                m_ops[m_idx] = m_acc; m_valid |= 1 << m_idx; m_idx++;
                m_acc = 0; m_dcnt = 0; m_done = (m_idx == NO) ? 1 : 0;
            end
        end
    endtask

    task automatic press(input int k, input int hold_f, input int rel_f);
        pressed = key_bit(k);
        repeat (hold_f * FR) @(negedge clk);
        pressed = '0;
        repeat (rel_f * FR) @(negedge clk);
    endtask

    task automatic press_chk(input int k);
        b = kv_cnt;
        press(k, 3, 3);
        chk("kv_pulses", kv_cnt - b, 1);
        chk("key_code", kv_last, k);
        m_apply(k);
    endtask

    // Park at the first negedge of a row-0 slot so frames line up with the stimulus
    task automatic align();
        int n = 0;
        while (bus.row !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
        while (bus.row !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
        chk("align_row", int'(bus.row), 14);
    endtask

    initial begin
        tbl = '{'{13, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 1, 0}, '{2, 0, 0, 0, 0, 2, 0},
                '{3, 0, 0, 0, 0, 3, 0},  '{4, 0, 0, 0, 0, 3, 0}, '{15, 123, 0, 1, 1, 0, 0},
                '{13, 0, 0, 0, 0, 0, 0}, '{4, 0, 0, 0, 0, 1, 0}, '{5, 0, 0, 0, 0, 2, 0},
                '{14, 0, 0, 0, 0, 1, 0}, '{6, 0, 0, 0, 0, 2, 0}, '{15, 46, 0, 1, 1, 0, 0},
                '{9, 46, 0, 1, 1, 1, 0}, '{15, 46, 9, 3, 2, 0, 1}, '{3, 46, 9, 3, 2, 0, 1},
                '{10, 46, 9, 3, 2, 0, 1}, '{14, 46, 9, 3, 2, 0, 1}};
        m_clear();
        repeat (3) @(negedge clk);
        chk("reset_row", int'(bus.row), 14);
        chk("reset_key_code", int'(bus.key_code), 0);
        chk("reset_key_valid", int'(bus.key_valid), 0);
        check_state(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        align();
        b = kv_cnt;
        pressed = key_bit(5);
        repeat (3 * FR) @(negedge clk);
        chk("hold5_pulses", kv_cnt - b, 1);
        chk("hold5_code", kv_last, 5);
        repeat (10 * FR) @(negedge clk);
        chk("hold5_no_repeat", kv_cnt - b, 1);
        pressed = '0;
        repeat (3 * FR) @(negedge clk);
        m_apply(5);
        check_model();

        align();
        b = kv_cnt;
        pressed = key_bit(7);
        repeat (FR) @(negedge clk);
        pressed = '0;
        repeat (FR) @(negedge clk);
        pressed = key_bit(7);
        repeat (FR + 2) @(negedge clk);
        chk("bounce_early", kv_cnt - b, 0);
        repeat (FR) @(negedge clk);
        chk("bounce_pulses", kv_cnt - b, 1);
        chk("bounce_code", kv_last, 7);
        pressed = '0;
        repeat (3 * FR) @(negedge clk);
        m_apply(7);
        check_model();

        foreach (tbl[i]) begin
            b = kv_cnt;
            press(tbl[i].key, 3, 3);
            chk("tbl_pulses", kv_cnt - b, 1);
            chk("tbl_code", kv_last, tbl[i].key);
            m_apply(tbl[i].key);
            check_state(tbl[i].op0, tbl[i].op1, tbl[i].valid, tbl[i].idx, tbl[i].dcnt, tbl[i].done);
        end

        b = kv_cnt;
        pressed = key_bit(2) | key_bit(8);
        repeat (4 * FR) @(negedge clk);
        pressed = '0;
        repeat (3 * FR) @(negedge clk);
        chk("ghost_pulses", kv_cnt - b, 0);
        check_model();
        press_chk(13);
        check_state(0, 0, 0, 0, 0, 0);

        press_chk(1);
        press_chk(2);
        check_model();
        align();
        pressed = key_bit(9);
        repeat (FR + 4) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_row", int'(bus.row), 14);
        chk("rst_key_code", int'(bus.key_code), 0);
        chk("rst_key_valid", int'(bus.key_valid), 0);
        check_state(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pressed = '0;
        repeat (3 * FR) @(negedge clk);
        m_clear();
        press_chk(8);
        check_model();

        repeat (30) begin
            int k;
            k = int'($urandom_range(0, 15));
            b = kv_cnt;
            press(k, int'($urandom_range(3, 4)), int'($urandom_range(3, 4)));
            chk("rnd_pulses", kv_cnt - b, 1);
            chk("rnd_code", kv_last, k);
            m_apply(k);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_multi_operand_entry.md
Name: keypad_multi_operand_entry

Overview:
Parameterised successor to the two-number keypad front end. It scans a 4x4 matrix keypad and debounces over whole scan frames. It decodes each press into a 4-bit key code and accumulates decimal digits into NUM_OPS binary operands, with backspace, enter and clear-all editing. Its outputs feed the arithmetic/display datapath directly.

Parameters:
SCAN_DIV, 50000, clk cycles each row is driven (one frame = 4*SCAN_DIV cycles); minimum 4
DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press or a release; minimum 1
NUM_OPS, 2, number of operands collected; range 1..8
MAX_DIGITS, 3, maximum decimal digits per operand
OUT_W, 10, operand width in bits; must satisfy 2^OUT_W > 10^MAX_DIGITS-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
col  in  4  keypad columns, active low (pulled up), asynchronous to clk
row  out  4  keypad rows, one-hot active low
operands  out  NUM_OPS*OUT_W  operand i in bits [i*OUT_W +: OUT_W]
op_valid  out  NUM_OPS  bit i high (sticky) once operand i is committed
key_code  out  4  code of the last accepted key
key_valid  out  1  one-cycle pulse on each accepted press
op_idx  out  $clog2(NUM_OPS+1)  index of the operand being entered
digit_cnt  out  $clog2(MAX_DIGITS+1)  digits held in the current accumulator
all_done  out  1  high once all NUM_OPS operands are committed

Behaviour:
- Reset (async, any time, including mid-entry or mid-debounce) sets: row=4'b1110; operands, op_valid, key_code, key_valid, op_idx, digit_cnt and all_done to 0. The accumulator, scan counters, debounce state and synchroniser are also cleared.
- Scan: row_sel cycles 0..3 and advances every SCAN_DIV cycles; row = ~(1<<row_sel).
- col passes through a 2-flop synchroniser. It is sampled on the last cycle of each row slot.
- Key map as (row, col0..col3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Key codes: digits map to their value, A=10, B=11, C=12, D=13, *=14, #=15.
- Frame result is evaluated after the row-3 sample:
  - exactly one low column across all four rows gives KEY(code);
  - no low column gives NONE;
  - more than one low column gives NONE (ghosting/multi-key rejected).
- Debounce FSM has states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: on KEY go to PRESS_WAIT (cnt=1, cand=code).
  - PRESS_WAIT: if the frame equals cand, cnt++; when cnt==DEBOUNCE_FRAMES, go to HELD, set key_code=cand and pulse key_valid for 1 cycle. Any differing frame goes back to IDLE.
  - HELD: no further pulses regardless of hold time (no auto-repeat). On NONE go to RELEASE_WAIT (cnt=1).
  - RELEASE_WAIT: NONE increments cnt; at DEBOUNCE_FRAMES go to IDLE. Any KEY frame returns to HELD.
- Entry actions are applied on the cycle after key_valid, so operands, op_valid, op_idx, digit_cnt and all_done update with 1-cycle latency.
  - Digit 0-9, when all_done=0 and digit_cnt<MAX_DIGITS: acc=acc*10+digit and digit_cnt++. When digit_cnt==MAX_DIGITS the digit is ignored.
  - * (backspace), when digit_cnt>0: acc=acc/10 and digit_cnt--. When digit_cnt==0 it is ignored.
  - # (enter), when digit_cnt>0 and all_done=0: operands[op_idx]=acc, op_valid[op_idx]=1, acc=0, digit_cnt=0, op_idx++. all_done=1 when op_idx reaches NUM_OPS. Enter with digit_cnt==0 is ignored.
  - D (clear): operands, op_valid, acc, digit_cnt, op_idx and all_done all return to 0.
  - A, B, C: reported on key_code/key_valid only; no entry action.
- While all_done=1, only D changes entry state. key_valid still pulses for every accepted key.
- acc is held internally at OUT_W bits; it is not visible until committed.

Test Plan:
- Run with SCAN_DIV=4, DEBOUNCE_FRAMES=2. Hold '5' for 3 frames -> exactly one key_valid with key_code=5, digit_cnt=1. 10 further frames held -> no further pulse.
- Bounce: '7' present 1 frame, NONE 1 frame, '7' for 2 frames -> single key_valid after the second consecutive '7' frame.
- Press 1,2,3,4,# -> the '4' is ignored; operands[0]=123, op_valid=01, op_idx=1.
- Press 4,5,*,6,# then 9,# -> operands[0]=46, operands[1]=9, op_valid=11, all_done=1. A further '3' pulses key_valid, but operands are unchanged.
- Press '2' and '8' simultaneously (two low columns) -> NONE, no key_valid. Then 'D' -> all entry outputs return to 0.
- Assert rst mid-PRESS_WAIT with digit_cnt=2 -> all outputs 0 immediately and row=1110. The first press after release is accepted normally.
